// File: rtl/input_shift_register.sv
// rtl/input_shift_register.sv - serial-in, parallel-out shift register of fixed-point words
module input_shift_register #(
  parameter int numInputs     = 32,
  parameter int dataWidth     = 4,
  parameter int dataFracWidth = 2,
  parameter int dataIntWidth  = 2,
  localparam int TOTAL = numInputs * dataWidth,
  localparam int CW    = $clog2(TOTAL + 1)
) (
  input  logic             serialClock,
  input  logic             reset,
  input  logic             serialData,
  output logic [TOTAL-1:0] dataOut,
  output logic [CW-1:0]    bitCount,
  output logic             full
);

  // The word format must account for every bit of a word.
  if (dataIntWidth + dataFracWidth != dataWidth) begin : g_bad_format
    $error("input_shift_register: dataIntWidth + dataFracWidth must equal dataWidth");
  end

  // The register needs at least two bits for the shift slice below to be legal.
  if (TOTAL < 2) begin : g_bad_size
    $error("input_shift_register: numInputs*dataWidth must be at least 2");
  end

  localparam logic [CW-1:0] COUNT_MAX = CW'(TOTAL);

  logic [TOTAL-1:0] data_q;
  logic [TOTAL-1:0] data_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Next state: new bit enters at the MSB; the count saturates once the register is full.
  always_comb begin
    data_d  = {serialData, data_q[TOTAL-1:1]};
    count_d = count_q;
    if (count_q != COUNT_MAX) begin
      count_d = count_q + CW'(1);
    end
  end

  // State register, cleared asynchronously; reset wins over a coincident edge.
  always_ff @(posedge serialClock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign dataOut  = data_q;
  assign bitCount = count_q;
  assign full     = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_input_shift_register.sv
// tb/tb_input_shift_register.sv - randomized self-checking bench for input_shift_register
module tb_input_shift_register;

  localparam int TOTAL_A = 128;
  localparam int CW_A    = 8;
  localparam int TOTAL_B = 16;
  localparam int CW_B    = 5;

  logic               serial_clock;
  logic               reset;
  logic               serial_data;
  logic [TOTAL_A-1:0] data_a;
  logic [CW_A-1:0]    count_a;
  logic               full_a;
  logic [TOTAL_B-1:0] data_b;
  logic [CW_B-1:0]    count_b;
  logic               full_b;

  int checks_done;
  int errors_found;

  // Every bit presented to the design since the last reset, oldest first.
  bit hist[$];

  input_shift_register dut_a (
    .serialClock (serial_clock),
    .reset       (reset),
    .serialData  (serial_data),
    .dataOut     (data_a),
    .bitCount    (count_a),
    .full        (full_a)
  );

  input_shift_register #(
    .numInputs     (2),
    .dataWidth     (8),
    .dataFracWidth (4),
    .dataIntWidth  (4)
  ) dut_b (
    .serialClock (serial_clock),
    .reset       (reset),
    .serialData  (serial_data),
    .dataOut     (data_b),
    .bitCount    (count_b),
    .full        (full_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_done++;
    if (got !== exp) begin
      errors_found++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The newest `total` bits of the history, newest at the top, oldest surviving at bit 0.
  function automatic logic [127:0] model_data(int total);
    logic [127:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int k = 0; k < total; k++) begin
      int idx;
      idx = n - total + k;
      if (idx >= 0) r[k] = hist[idx];
    end
    return r;
  endfunction

  function automatic int model_count(int total);
    return (hist.size() < total) ? hist.size() : total;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".data_a"},  128'(data_a),  model_data(TOTAL_A));
    check({tag, ".count_a"}, 128'(count_a), 128'(model_count(TOTAL_A)));
    check({tag, ".full_a"},  128'(full_a),  128'(hist.size() >= TOTAL_A));
    check({tag, ".data_b"},  128'(data_b),  model_data(TOTAL_B));
    check({tag, ".count_b"}, 128'(count_b), 128'(model_count(TOTAL_B)));
    check({tag, ".full_b"},  128'(full_b),  128'(hist.size() >= TOTAL_B));
  endtask

  // One full clock period with the bit set up while the clock is low; returns just after the falling edge.
  task automatic shift_bit(input bit b);
    serial_data = b;
    #5 serial_clock = 1'b1;
    hist.push_back(b);
    #5 serial_clock = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hist.delete();
    #10 reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0]  word;
    logic [127:0] prev;
    logic [127:0] alt;
    checks_done  = 0;
    errors_found = 0;
    serial_clock = 1'b0;
    serial_data  = 1'b0;

    // Reset held 20 ns with the clock idle.
    reset = 1'b1;
    #20;
    check("rst.data_a",  128'(data_a),  128'd0);
    check("rst.count_a", 128'(count_a), 128'd0);
    check("rst.full_a",  128'(full_a),  128'd0);
    check("rst.data_b",  128'(data_b),  128'd0);
    reset = 1'b0;
    #3;

    // 32-bit word sent LSB first lands in the top 32 bits.
    word = 32'hFF203040;
    for (int i = 0; i < 32; i++) shift_bit(word[i]);
    check_all("word");
    check("word.top",    128'(data_a[127:96]), 128'h0000_0000_0000_0000_0000_0000_FF20_3040);
    check("word.low",    128'(data_a[95:0]),   128'd0);
    check("word.count",  128'(count_a),        128'd32);
    check("word.full",   128'(full_a),         128'd0);
    check("word.w31",    128'(data_a[31*4 +: 4]), 128'hF);
    check("word.w25",    128'(data_a[25*4 +: 4]), 128'h4);
    check("word.w24",    128'(data_a[24*4 +: 4]), 128'h0);

    // 128 alternating bits starting with 1 fill the register exactly.
    do_reset();
    for (int i = 0; i < TOTAL_A; i++) shift_bit(((i % 2) == 0) ? 1'b1 : 1'b0);
    alt = {64{2'b01}};
    check_all("alt");
    check("alt.data",  128'(data_a),  alt);
    check("alt.bit0",  128'(data_a[0]), 128'd1);
    check("alt.count", 128'(count_a), 128'd128);
    check("alt.full",  128'(full_a),  128'd1);

    // One more bit past full: oldest bit dropped, count holds.
    prev = data_a;
    shift_bit(1'b0);
    check_all("over");
    check("over.data",  128'(data_a),  {1'b0, prev[127:1]});
    check("over.count", 128'(count_a), 128'd128);
    check("over.full",  128'(full_a),  128'd1);

    // Asynchronous reset between edges after 10 bits, then restart from zero.
    do_reset();
    for (int i = 0; i < 10; i++) shift_bit(1'($urandom_range(0, 1)));
    check_all("pre_async");
    #2 reset = 1'b1;
    hist.delete();
    #1;
    check("async.data_a",  128'(data_a),  128'd0);
    check("async.count_a", 128'(count_a), 128'd0);
    check("async.full_a",  128'(full_a),  128'd0);
    // Clock edges while reset is held change nothing.
    for (int i = 0; i < 3; i++) begin
      serial_data = 1'b1;
      #5 serial_clock = 1'b1;
      #5 serial_clock = 1'b0;
    end
    #1;
    check("held.data_a",  128'(data_a),  128'd0);
    check("held.count_a", 128'(count_a), 128'd0);
    reset = 1'b0;
    #3;
    shift_bit(1'b1);
    check_all("restart");
    check("restart.count", 128'(count_a), 128'd1);

    // Long random stream with occasional mid-stream resets, checked every cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
        hist.delete();
        #3 reset = 1'b0;
        #1;
        check_all("rand_rst");
      end
      shift_bit(1'($urandom_range(0, 1)));
      check_all("rand");
    end

    // Overridden instance: 16 ones fill it completely.
    do_reset();
    for (int i = 0; i < 16; i++) shift_bit(1'b1);
    check("ovr.data_b",  128'(data_b),  128'hFFFF);
    check("ovr.full_b",  128'(full_b),  128'd1);
    check("ovr.count_b", 128'(count_b), 128'd16);
    check_all("ovr");

    // Reset rising together with a clock edge: reset wins.
    serial_data = 1'b1;
    #4;
    reset = 1'b1;
    serial_clock = 1'b1;
    hist.delete();
    #1;
    check("coinc.data_a",  128'(data_a),  128'd0);
    check("coinc.count_a", 128'(count_a), 128'd0);
    check("coinc.full_b",  128'(full_b),  128'd0);
    #4 serial_clock = 1'b0;
    #2 reset = 1'b0;
    #3;
    shift_bit(1'b1);
    check_all("after_coinc");

    $display("Simulation finished: %0d checks, %0d errors", checks_done, errors_found);
    $finish;
  end

endmodule
